adder_arbiter_2p: RTL and testbench
===================================

ADDER_ARBITER_2P -- requirements
Module: adder_arbiter_2p

Interface
REQ-001 Parameter: FAIR, default 1; 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 Ports (clock and reset first):
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high until done0.
- a0, b0  input  8 each  port 0 operands.
- c0  input  1  port 0 carry-in.
- req1, a1, b1, c1  input  1/8/8/1  port 1 equivalents.
- gnt0, gnt1  output  1 each  one-cycle grant pulse; operands latched this cycle.
- done0, done1  output  1 each  one-cycle result-valid pulse for the granted port.
- sum  output  8  registered result of the latched operands.
- carry  output  1  registered carry-out.
- busy  output  1  high in EXEC and DONE states.
REQ-003 The shared adder SHALL be a single instance of the team's adder_8bit (ports A, B, C, sum, carry); no second adder is permitted.

Function
REQ-004 FSM states SHALL be IDLE, GRANT, EXEC and DONE, encoded as a 2-bit state.
REQ-005 In IDLE with any req high at edge t, the block SHALL go to GRANT; gnt_x SHALL be high during cycle t+1 and the winner's a/b/c SHALL be latched at the end of cycle t+1.
REQ-006 GRANT SHALL always go to EXEC; EXEC SHALL register adder sum/carry into sum/carry and go to DONE; done_x SHALL be high for exactly the DONE cycle (t+3).
REQ-007 DONE SHALL always return to IDLE; latency from req sampled to done is 3 cycles, throughput one operation per 4 cycles.
REQ-008 Arbitration with FAIR=1: when both req high in IDLE, grant SHALL go to the port not served last; a last_port register SHALL update on each grant.
REQ-009 Arbitration with FAIR=0: port 0 SHALL win whenever req0 is high.
REQ-010 A single requesting port SHALL be granted regardless of last_port.
REQ-011 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle; done_x SHALL match the port granted.
REQ-012 req inputs SHALL be ignored in GRANT, EXEC and DONE; a req still high when IDLE is re-entered SHALL be treated as a new request.
REQ-013 Operand changes after the latch edge SHALL not affect the in-flight result.
REQ-014 sum/carry SHALL hold the last result until the next EXEC; carry SHALL equal bit 8 of a+b+c (e.g. 0xFF+0x01+0 -> sum 0x00, carry 1).

Reset
REQ-015 When rst is high at an edge: state <= IDLE, last_port <= 1 (port 0 wins first tie), sum <= 0, carry <= 0, latched operands <= 0.
REQ-016 gnt0, gnt1, done0, done1, busy SHALL be 0 in the cycle after reset; rst mid-operation SHALL abort without any done pulse.
REQ-017 rst SHALL take priority over all other inputs in the same cycle.

Structure
REQ-018 State encoding constants and port-index constants SHALL live in a shared package, adder_arb_pkg.
REQ-019 The only sub-module SHALL be adder_8bit; arbitration and FSM logic stay in adder_arbiter_2p.

Verification
REQ-020 Single request: req0=1, a0=0x10, b0=0x12, c0=1 -> gnt0 at t+1, done0 at t+3, sum=0x23, carry=0.
REQ-021 Overflow: req1=1, a1=0xAA, b1=0xAD, c1=0 -> done1 at t+3, sum=0x57, carry=1.
REQ-022 Tie round-robin (FAIR=1): req0=req1=1 held, first grant after reset -> port 0; after it completes, port 1; alternation continues.
REQ-023 Fixed priority (FAIR=0): req0=req1=1 held over 3 operations -> all grants to port 0, port 1 never granted.
REQ-024 Operand stability: change a0 from 0x20 to 0x64 in EXEC cycle -> result still uses 0x20.
REQ-025 Reset mid-op: assert rst in EXEC -> next cycle state IDLE, sum=0x00, carry=0, no done pulse.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared constants for the two-port adder arbiter: FSM state encoding and port indices.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/adder_8bit.sv
// Purely combinational 8-bit adder with carry-in and carry-out.
module adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       C,
    output logic [7:0] sum,
    output logic       carry
);

    logic [8:0] w_full;

    assign w_full = {1'b0, A} + {1'b0, B} + {8'd0, C};
    assign sum    = w_full[7:0];
    assign carry  = w_full[8];

endmodule

// File: rtl/adder_arbiter_2p.sv
// Two requesters share one 8-bit adder; a 4-state FSM grants, latches operands,
// executes and reports the result, one operation every four cycles.
module adder_arbiter_2p
    import adder_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       c0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       c1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] sum,
    output logic       carry,
    output logic       busy
);

    state_t     r_state;
    logic       r_last_port;
    logic       r_sel;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_c;
    logic [7:0] r_sum;
    logic       r_carry;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_done0;
    logic       r_done1;
    logic       r_busy;

    logic       w_winner;
    logic [7:0] w_sum;
    logic       w_carry;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_winner = PORT0;
        if (req0 && req1) begin
            // Round-robin favours the port not served last; fixed mode always favours port 0.
            w_winner = (FAIR != 0) ? ~r_last_port : PORT0;
        end else if (req1) begin
            w_winner = PORT1;
        end
    end

    adder_8bit u_adder (
        .A    (r_a),
        .B    (r_b),
        .C    (r_c),
        .sum  (w_sum),
        .carry(w_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_port <= PORT1;
            r_sel       <= PORT0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_c         <= 1'b0;
            r_sum       <= 8'd0;
            r_carry     <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (req0 || req1) begin
                        r_state     <= ST_GRANT;
                        r_sel       <= w_winner;
                        r_last_port <= w_winner;
                        r_gnt0      <= (w_winner == PORT0);
                        r_gnt1      <= (w_winner == PORT1);
                    end
                end
                ST_GRANT: begin
                    r_a     <= (r_sel == PORT1) ? a1 : a0;
                    r_b     <= (r_sel == PORT1) ? b1 : b0;
                    r_c     <= (r_sel == PORT1) ? c1 : c0;
                    r_busy  <= 1'b1;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_sum   <= w_sum;
                    r_carry <= w_carry;
                    r_done0 <= (r_sel == PORT0);
                    r_done1 <= (r_sel == PORT1);
                    r_busy  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign done0 = r_done0;
    assign done1 = r_done1;
    assign sum   = r_sum;
    assign carry = r_carry;
    assign busy  = r_busy;

endmodule

// File: tb/tb_adder_arbiter_2p.sv
// Directed bench driving a round-robin and a fixed-priority arbiter from shared inputs.
module tb_adder_arbiter_2p;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, c0, c1;
    logic [7:0] a0, b0, a1, b1;

    logic       f_gnt0, f_gnt1, f_done0, f_done1, f_carry, f_busy;
    logic       p_gnt0, p_gnt1, p_done0, p_done1, p_carry, p_busy;
    logic [7:0] f_sum, p_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_arbiter_2p #(.FAIR(1)) u_fair (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .c0(c0),
        .req1(req1), .a1(a1), .b1(b1), .c1(c1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
        .sum(f_sum), .carry(f_carry), .busy(f_busy)
    );

    adder_arbiter_2p #(.FAIR(0)) u_fixed (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .c0(c0),
        .req1(req1), .a1(a1), .b1(b1), .c1(c1),
        .gnt0(p_gnt0), .gnt1(p_gnt1), .done0(p_done0), .done1(p_done1),
        .sum(p_sum), .carry(p_carry), .busy(p_busy)
    );

    typedef struct {
        logic       r0;
        logic       r1;
        logic [7:0] a0;
        logic [7:0] b0;
        logic       c0;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       c1;
        logic       f_port;
        logic [7:0] f_sum;
        logic       f_carry;
        logic       p_port;
        logic [7:0] p_sum;
        logic       p_carry;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag,
                             input logic g0, input logic g1, input logic d0, input logic d1, input logic bz,
                             input logic eg0, input logic eg1, input logic ed0, input logic ed1, input logic ebz);
        check({tag, " gnt0"}, {31'd0, g0}, {31'd0, eg0});
        check({tag, " gnt1"}, {31'd0, g1}, {31'd0, eg1});
        check({tag, " done0"}, {31'd0, d0}, {31'd0, ed0});
        check({tag, " done1"}, {31'd0, d1}, {31'd0, ed1});
        check({tag, " busy"}, {31'd0, bz}, {31'd0, ebz});
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        check_ctl("reset fair", f_gnt0, f_gnt1, f_done0, f_done1, f_busy, 0, 0, 0, 0, 0);
        check_ctl("reset fixed", p_gnt0, p_gnt1, p_done0, p_done1, p_busy, 0, 0, 0, 0, 0);
        check("reset sum", {23'd0, f_carry, f_sum}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        string tag;
        rst = 1'b1;
        {req0, req1, c0, c1} = '0;
        {a0, b0, a1, b1}     = '0;

        //            r0 r1 a0     b0     c0 a1     b1     c1 fport fsum   fc pport psum   pc
        vecs[0] = '{1, 0, 8'h10, 8'h12, 1, 8'h00, 8'h00, 0, 0, 8'h23, 0, 0, 8'h23, 0};
        vecs[1] = '{0, 1, 8'h00, 8'h00, 0, 8'hAA, 8'hAD, 0, 1, 8'h57, 1, 1, 8'h57, 1};
        vecs[2] = '{1, 1, 8'h01, 8'h02, 0, 8'h80, 8'h80, 1, 0, 8'h03, 0, 0, 8'h03, 0};
        vecs[3] = '{1, 1, 8'h01, 8'h02, 0, 8'h80, 8'h80, 1, 1, 8'h01, 1, 0, 8'h03, 0};
        vecs[4] = '{1, 1, 8'hFF, 8'h01, 0, 8'h0F, 8'h0F, 1, 0, 8'h00, 1, 0, 8'h00, 1};
        vecs[5] = '{1, 1, 8'hFF, 8'h01, 0, 8'h0F, 8'h0F, 1, 1, 8'h1F, 0, 0, 8'h00, 1};
        vecs[6] = '{0, 1, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 1, 1, 8'hFF, 1, 1, 8'hFF, 1};
        vecs[7] = '{1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0};

        do_reset();

        // Each vector is one full operation: grant at t+1, busy at t+2, done at t+3, idle at t+4.
        for (int i = 0; i < 8; i++) begin
            req0 = vecs[i].r0; a0 = vecs[i].a0; b0 = vecs[i].b0; c0 = vecs[i].c0;
            req1 = vecs[i].r1; a1 = vecs[i].a1; b1 = vecs[i].b1; c1 = vecs[i].c1;
            @(negedge clk);
            tag = $sformatf("vec%0d t+1", i);
            check_ctl({tag, " fair"}, f_gnt0, f_gnt1, f_done0, f_done1, f_busy,
                      !vecs[i].f_port, vecs[i].f_port, 0, 0, 0);
            check_ctl({tag, " fixed"}, p_gnt0, p_gnt1, p_done0, p_done1, p_busy,
                      !vecs[i].p_port, vecs[i].p_port, 0, 0, 0);
            @(negedge clk);
            tag = $sformatf("vec%0d t+2", i);
            check_ctl({tag, " fair"}, f_gnt0, f_gnt1, f_done0, f_done1, f_busy, 0, 0, 0, 0, 1);
            check_ctl({tag, " fixed"}, p_gnt0, p_gnt1, p_done0, p_done1, p_busy, 0, 0, 0, 0, 1);
            @(negedge clk);
            tag = $sformatf("vec%0d t+3", i);
            check_ctl({tag, " fair"}, f_gnt0, f_gnt1, f_done0, f_done1, f_busy,
                      0, 0, !vecs[i].f_port, vecs[i].f_port, 1);
            check_ctl({tag, " fixed"}, p_gnt0, p_gnt1, p_done0, p_done1, p_busy,
                      0, 0, !vecs[i].p_port, vecs[i].p_port, 1);
            check({tag, " fair sum"}, {24'd0, f_sum}, {24'd0, vecs[i].f_sum});
            check({tag, " fair carry"}, {31'd0, f_carry}, {31'd0, vecs[i].f_carry});
            check({tag, " fixed sum"}, {24'd0, p_sum}, {24'd0, vecs[i].p_sum});
            check({tag, " fixed carry"}, {31'd0, p_carry}, {31'd0, vecs[i].p_carry});
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
            tag = $sformatf("vec%0d t+4", i);
            check_ctl({tag, " fair"}, f_gnt0, f_gnt1, f_done0, f_done1, f_busy, 0, 0, 0, 0, 0);
            check_ctl({tag, " fixed"}, p_gnt0, p_gnt1, p_done0, p_done1, p_busy, 0, 0, 0, 0, 0);
            check({tag, " fair sum hold"}, {24'd0, f_sum}, {24'd0, vecs[i].f_sum});
        end

        // Both requests held over three operations straight after reset.
        do_reset();
        req0 = 1'b1; a0 = 8'h01; b0 = 8'h01; c0 = 1'b0;
        req1 = 1'b1; a1 = 8'h02; b1 = 8'h02; c1 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            tag = $sformatf("held n%0d", n);
            check_ctl({tag, " fair"}, f_gnt0, f_gnt1, f_done0, f_done1, f_busy,
                      (n == 1 || n == 9), (n == 5), (n == 3 || n == 11), (n == 7),
                      (n % 4 == 2 || n % 4 == 3));
            check_ctl({tag, " fixed"}, p_gnt0, p_gnt1, p_done0, p_done1, p_busy,
                      (n % 4 == 1), 0, (n % 4 == 3), 0,
                      (n % 4 == 2 || n % 4 == 3));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("held fair last sum", {24'd0, f_sum}, 32'h02);
        check("held fixed last sum", {24'd0, p_sum}, 32'h02);
        @(negedge clk);

        // Operand change during EXEC must not reach the in-flight result.
        req0 = 1'b1; a0 = 8'h20; b0 = 8'h01; c0 = 1'b0;
        @(negedge clk);
        check("stable gnt0", {31'd0, f_gnt0}, 32'd1);
        @(negedge clk);
        a0 = 8'h64;
        @(negedge clk);
        check("stable done0", {31'd0, f_done0}, 32'd1);
        check("stable fair sum", {24'd0, f_sum}, 32'h21);
        check("stable fixed sum", {24'd0, p_sum}, 32'h21);
        check("stable carry", {31'd0, f_carry}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);

        // Reset asserted during EXEC aborts the operation with no done pulse.
        req0 = 1'b1; a0 = 8'h30; b0 = 8'h30; c0 = 1'b0;
        @(negedge clk);
        check("abort gnt0", {31'd0, f_gnt0}, 32'd1);
        @(negedge clk);
        check("abort busy exec", {31'd0, f_busy}, 32'd1);
        rst  = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        check_ctl("abort fair", f_gnt0, f_gnt1, f_done0, f_done1, f_busy, 0, 0, 0, 0, 0);
        check_ctl("abort fixed", p_gnt0, p_gnt1, p_done0, p_done1, p_busy, 0, 0, 0, 0, 0);
        check("abort sum", {23'd0, f_carry, f_sum}, 32'd0);
        check("abort fixed sum", {23'd0, p_carry, p_sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort late done0", {31'd0, f_done0}, 32'd0);
        check("abort late sum", {24'd0, f_sum}, 32'd0);

        // Recovery: a fresh port-1 request completes normally.
        req1 = 1'b1; a1 = 8'h01; b1 = 8'h01; c1 = 1'b1;
        @(negedge clk);
        check("recover gnt1", {31'd0, f_gnt1}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("recover done1", {31'd0, f_done1}, 32'd1);
        check("recover sum", {24'd0, f_sum}, 32'h03);
        req1 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
